// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared FSM state type and default width for seq_divider.
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam int c_DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } div_state_t;

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One radix-2 restoring iteration: shift, trial subtract, restore.
// Revision    : 1.0 - initial release
// ============================================================================
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_trial;
    logic             w_fits;

    // Dividend bits stream in MSB first from the top of the quotient register.
    assign w_shift = {rem_in, quo_in[WIDTH-1]};
    assign w_trial = w_shift - {2'b00, divisor};
    assign w_fits  = ~w_trial[WIDTH+1];

    assign rem_out = w_fits ? w_trial[WIDTH:0] : w_shift[WIDTH:0];
    assign quo_out = {quo_in[WIDTH-2:0], w_fits};

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Sequential signed/unsigned divider, one quotient bit per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int c_CNT_W = $clog2(WIDTH + 1);

    div_state_t         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dsr;
    logic               r_signed;
    logic               r_neg_a;
    logic               r_neg_b;
    logic               r_dz;

    logic [WIDTH:0]     w_step_rem;
    logic [WIDTH-1:0]   w_step_quo;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_neg_q;
    logic               w_neg_r;

    assign w_mag_a = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    assign w_mag_b = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    assign w_neg_q = r_signed & (r_neg_a ^ r_neg_b);
    assign w_neg_r = r_signed & r_neg_a;

    assign busy = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done = (r_state == S_DONE);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (r_rem),
        .quo_in  (r_quo),
        .divisor (r_dsr),
        .rem_out (w_step_rem),
        .quo_out (w_step_quo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dsr       <= '0;
            r_signed    <= 1'b0;
            r_neg_a     <= 1'b0;
            r_neg_b     <= 1'b0;
            r_dz        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_signed <= is_signed;
                        r_neg_a  <= dividend[WIDTH-1];
                        r_neg_b  <= divisor[WIDTH-1];
                        r_rem    <= '0;
                        r_quo    <= w_mag_a;
                        r_dsr    <= w_mag_b;
                        // Zero divisor skips CALC but spends one extra FIX cycle.
                        if (divisor == '0) begin
                            r_dz    <= 1'b1;
                            r_cnt   <= c_CNT_W'(1);
                            r_state <= S_FIX;
                        end else begin
                            r_dz    <= 1'b0;
                            r_cnt   <= c_CNT_W'(WIDTH);
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (r_cnt == '0) begin
                        r_state <= S_FIX;
                    end else begin
                        r_rem <= w_step_rem;
                        r_quo <= w_step_quo;
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_FIX: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        div_by_zero <= r_dz;
                        if (r_dz) begin
                            quotient  <= '1;
                            remainder <= w_neg_r ? -r_quo : r_quo;
                        end else begin
                            quotient  <= w_neg_q ? -r_quo : r_quo;
                            remainder <= w_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
                        end
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider
// Description : Scoreboard bench for seq_divider at WIDTH=32 and WIDTH=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        logic        dz;
        int unsigned acc;
        int unsigned lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned cyc = 0;
    int          checks = 0;
    int          fails = 0;

    logic        s32_start, s32_sgn, b32_busy, d32_done, z32;
    logic [31:0] s32_a, s32_b, q32, r32;
    logic        s8_start, s8_sgn, b8_busy, d8_done, z8;
    logic [7:0]  s8_a, s8_b, q8, r8;

    exp_t sb32[$];
    exp_t sb8[$];
    exp_t m32, m8;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_divider #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(s32_start), .is_signed(s32_sgn),
        .dividend(s32_a), .divisor(s32_b), .busy(b32_busy), .done(d32_done),
        .quotient(q32), .remainder(r32), .div_by_zero(z32)
    );

    seq_divider #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8_start), .is_signed(s8_sgn),
        .dividend(s8_a), .divisor(s8_b), .busy(b8_busy), .done(d8_done),
        .quotient(q8), .remainder(r8), .div_by_zero(z8)
    );

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division, truncating toward zero when signed.
    function automatic exp_t model(int w, logic sgn, logic [63:0] a, logic [63:0] b);
        exp_t        e;
        logic [63:0] mask;
        longint      sa, sd;
        mask = (64'd1 << w) - 64'd1;
        e = '{q: 0, r: 0, dz: 0, acc: 0, lat: 0};
        if (b == 64'd0) begin
            e.q = mask; e.r = a; e.dz = 1'b1; e.lat = 2;
        end else begin
            e.lat = w + 2;
            if (sgn) begin
                sa = a[w-1] ? longint'(a | ~mask) : longint'(a);
                sd = b[w-1] ? longint'(b | ~mask) : longint'(b);
                e.q = 64'(sa / sd) & mask;
                e.r = 64'(sa % sd) & mask;
            end else begin
                e.q = a / b;
                e.r = a % b;
            end
        end
        return e;
    endfunction

    function automatic exp_t mk(logic [63:0] q, logic [63:0] r, logic dz, int unsigned lat);
        exp_t e;
        e = '{q: q, r: r, dz: dz, acc: 0, lat: lat};
        return e;
    endfunction

    function automatic logic [63:0] pick(int w);
        logic [63:0] mask, v;
        mask = (64'd1 << w) - 64'd1;
        case ($urandom_range(0, 9))
            0:       v = 64'd0;
            1:       v = mask;
            2:       v = 64'd1 << (w - 1);
            3:       v = 64'd1;
            4:       v = 64'($urandom_range(1, 20));
            default: v = {$urandom, $urandom};
        endcase
        return v & mask;
    endfunction

    task automatic wait_done32();
        int n = 0;
        while (!d32_done && n < 100) begin @(negedge clk); n++; end
        if (!d32_done) begin
            checks++; fails++;
            $display("FAIL timeout32: got no done expected done within 100 cycles");
        end
    endtask

    task automatic wait_done8();
        int n = 0;
        while (!d8_done && n < 100) begin @(negedge clk); n++; end
        if (!d8_done) begin
            checks++; fails++;
            $display("FAIL timeout8: got no done expected done within 100 cycles");
        end
    endtask

    task automatic issue32(logic sgn, logic [31:0] a, logic [31:0] b, exp_t e);
        @(negedge clk);
        s32_sgn = sgn; s32_a = a; s32_b = b; s32_start = 1'b1;
        @(posedge clk); #1;
        e.acc = cyc;
        sb32.push_back(e);
        s32_start = 1'b0; s32_sgn = ~sgn; s32_a = $urandom; s32_b = $urandom;
        wait_done32();
    endtask

    task automatic issue8(logic sgn, logic [7:0] a, logic [7:0] b, exp_t e);
        @(negedge clk);
        s8_sgn = sgn; s8_a = a; s8_b = b; s8_start = 1'b1;
        @(posedge clk); #1;
        e.acc = cyc;
        sb8.push_back(e);
        s8_start = 1'b0; s8_a = 8'($urandom); s8_b = 8'($urandom);
        wait_done8();
    endtask

    task automatic check_zero_outputs(string tag);
        check({tag, "_busy32"}, b32_busy, 0);
        check({tag, "_done32"}, d32_done, 0);
        check({tag, "_q32"}, q32, 0);
        check({tag, "_r32"}, r32, 0);
        check({tag, "_dz32"}, z32, 0);
        check({tag, "_q8"}, q8, 0);
        check({tag, "_r8"}, r8, 0);
        check({tag, "_dz8"}, z8, 0);
    endtask

    always @(negedge clk) begin
        if (d32_done) begin
            check("busy_done_excl32", b32_busy, 0);
            if (sb32.size() == 0) begin
                checks++; fails++;
                $display("FAIL unexpected_done32: got done=1 expected no pending result");
            end else begin
                m32 = sb32.pop_front();
                check("quotient32", q32, m32.q);
                check("remainder32", r32, m32.r);
                check("div_by_zero32", z32, m32.dz);
                check("latency32", cyc - m32.acc, m32.lat);
            end
        end
    end

    always @(negedge clk) begin
        if (d8_done) begin
            check("busy_done_excl8", b8_busy, 0);
            if (sb8.size() == 0) begin
                checks++; fails++;
                $display("FAIL unexpected_done8: got done=1 expected no pending result");
            end else begin
                m8 = sb8.pop_front();
                check("quotient8", q8, m8.q);
                check("remainder8", r8, m8.r);
                check("div_by_zero8", z8, m8.dz);
                check("latency8", cyc - m8.acc, m8.lat);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish before 500000");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        s32_start = 0; s32_sgn = 0; s32_a = 0; s32_b = 0;
        s8_start = 0; s8_sgn = 0; s8_a = 0; s8_b = 0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;

        issue8(1'b1, 8'h80, 8'hFF, mk(64'h80, 64'h0, 0, 10));
        issue8(1'b0, 8'hFF, 8'h10, mk(64'h0F, 64'h0F, 0, 10));

        issue32(1'b0, 32'd100, 32'd7, mk(64'd14, 64'd2, 0, 34));
        issue32(1'b1, -32'sd7, 32'sd2, mk(64'hFFFFFFFD, 64'hFFFFFFFF, 0, 34));
        issue32(1'b1, 32'sd7, -32'sd2, mk(64'hFFFFFFFD, 64'd1, 0, 34));
        issue32(1'b1, 32'h80000000, 32'hFFFFFFFF, mk(64'h80000000, 64'd0, 0, 34));
        issue32(1'b0, 32'h80000000, 32'd1, mk(64'h80000000, 64'd0, 0, 34));

        // start during the DONE cycle must be dropped
        s32_sgn = 1'b0; s32_a = 32'd5; s32_b = 32'd1; s32_start = 1'b1;
        @(posedge clk); #1 s32_start = 1'b0;
        @(negedge clk);
        check("done_cycle_start_ignored", b32_busy, 0);

        issue32(1'b1, -32'sd55, 32'd0, mk(64'hFFFFFFFF, 64'hFFFFFFC9, 1, 2));
        issue32(1'b0, 32'd55, 32'd0, mk(64'hFFFFFFFF, 64'd55, 1, 2));

        // Abort: second start at cycle 5 ignored, reset around cycle 10
        @(negedge clk);
        s32_sgn = 1'b0; s32_a = 32'd1000; s32_b = 32'd3; s32_start = 1'b1;
        @(posedge clk); #1 s32_start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        s32_a = 32'd9; s32_b = 32'd3; s32_start = 1'b1;
        @(posedge clk); #1 s32_start = 1'b0;
        check("busy_after_second_start", b32_busy, 1);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_zero_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (45) @(negedge clk);
        check("idle_after_abort", b32_busy, 0);
        check("q_held_after_abort", q32, 0);
        issue32(1'b0, 32'd1000, 32'd3, mk(64'd333, 64'd1, 0, 34));

        fork
            begin
                repeat (40) begin
                    logic        sg;
                    logic [63:0] a, b;
                    sg = 1'($urandom);
                    a = pick(32); b = pick(32);
                    issue32(sg, a[31:0], b[31:0], model(32, sg, a, b));
                end
            end
            begin
                repeat (80) begin
                    logic        sg;
                    logic [63:0] a, b;
                    sg = 1'($urandom);
                    a = pick(8); b = pick(8);
                    issue8(sg, a[7:0], b[7:0], model(8, sg, a, b));
                end
            end
        join

        repeat (5) @(negedge clk);
        check("sb32_drained", 64'(sb32.size()), 0);
        check("sb8_drained", 64'(sb8.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
